// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with a busy scoreboard and a post-reset
// clear sequencer. After reset the sequencer zeroes one entry per cycle. Once
// every entry is zero the file enters RUN and accepts writes and reservations.
// Optional feature: define REGFILE_BYPASS_EN to forward write data to the
// read ports in the same cycle as the write.
module regfile_mp #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NREAD      = 2,
  parameter int NWRITE     = 2,
  parameter int ZERO_REG   = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         ready,
  input  logic [NWRITE-1:0]            wen,
  input  logic [NWRITE*ADDR_WIDTH-1:0] waddr,
  input  logic [NWRITE*DATA_WIDTH-1:0] wdata,
  input  logic [NREAD*ADDR_WIDTH-1:0]  raddr,
  output logic [NREAD*DATA_WIDTH-1:0]  rdata,
  output logic [NREAD-1:0]             rbusy,
  input  logic                         rsv_en,
  input  logic [ADDR_WIDTH-1:0]        rsv_addr
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = {ADDR_WIDTH{1'b1}};

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_ptr_q, clr_ptr_d;
  logic [DATA_WIDTH-1:0]   rf_q [DEPTH];
  logic [DATA_WIDTH-1:0]   rf_d [DEPTH];
  logic [DEPTH-1:0]        busy_q, busy_d;

  // Entry 0 is hard-wired to zero when ZERO_REG is set.
  function automatic logic is_zero_entry(input logic [ADDR_WIDTH-1:0] a);
    return (ZERO_REG != 0) && (a == {ADDR_WIDTH{1'b0}});
  endfunction

  // State register, clear pointer and scoreboard. A reset restarts the clear sequence.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      clr_ptr_q <= {ADDR_WIDTH{1'b0}};
      busy_q    <= {DEPTH{1'b0}};
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      busy_q    <= busy_d;
    end
  end

  // Storage flops. These have no reset because the clear sequence initialises them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int e = 0; e < DEPTH; e++) begin
        rf_q[e] <= rf_d[e];
      end
    end
  end

  // Next-state logic: CLEAR runs until the last entry has been zeroed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CLEAR: begin
        if (clr_ptr_q == LAST_IDX) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_CLEAR;
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_CLEAR;
    endcase
  end

  // Datapath next state: either clear one entry, or apply writes and then the reservation.
  always_comb begin
    clr_ptr_d = clr_ptr_q;
    busy_d    = busy_q;
    for (int e = 0; e < DEPTH; e++) begin
      rf_d[e] = rf_q[e];
    end
    if (state_q == ST_CLEAR) begin
      rf_d[clr_ptr_q] = {DATA_WIDTH{1'b0}};
      clr_ptr_d       = clr_ptr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      // Ascending port order lets the highest enabled port win on an address clash.
      for (int k = 0; k < NWRITE; k++) begin
        if (wen[k] && !is_zero_entry(waddr[k*ADDR_WIDTH +: ADDR_WIDTH])) begin
          rf_d[waddr[k*ADDR_WIDTH +: ADDR_WIDTH]]   = wdata[k*DATA_WIDTH +: DATA_WIDTH];
          busy_d[waddr[k*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
        end
      end
      // A reservation comes after the writes so that the new producer keeps the entry busy.
      if (rsv_en && !is_zero_entry(rsv_addr)) begin
        busy_d[rsv_addr] = 1'b1;
      end else begin
        busy_d = busy_d;
      end
    end
  end

  // Output logic: ready flag and the asynchronous read ports, with optional forwarding.
  always_comb begin
    ready = (state_q == ST_RUN);
    rdata = {(NREAD*DATA_WIDTH){1'b0}};
    rbusy = {NREAD{1'b0}};
    for (int i = 0; i < NREAD; i++) begin
      if (state_q != ST_RUN || is_zero_entry(raddr[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
        rdata[i*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{1'b0}};
        rbusy[i]                          = 1'b0;
      end else begin
        rdata[i*DATA_WIDTH +: DATA_WIDTH] = rf_q[raddr[i*ADDR_WIDTH +: ADDR_WIDTH]];
        rbusy[i]                          = busy_q[raddr[i*ADDR_WIDTH +: ADDR_WIDTH]];
`ifdef REGFILE_BYPASS_EN
        for (int k = 0; k < NWRITE; k++) begin
          if (wen[k] && (waddr[k*ADDR_WIDTH +: ADDR_WIDTH] == raddr[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
            rdata[i*DATA_WIDTH +: DATA_WIDTH] = wdata[k*DATA_WIDTH +: DATA_WIDTH];
            rbusy[i] = rsv_en && (rsv_addr == raddr[i*ADDR_WIDTH +: ADDR_WIDTH]);
          end
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp. It applies directed scenarios followed
// by random traffic. The expected values come from a register-level model
// that is updated once per clock edge.
module tb_regfile_mp;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 2;
  localparam int NW = 2;
  localparam int DEPTH = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              ready;
  logic [NW-1:0]     wen;
  logic [NW*AW-1:0]  waddr;
  logic [NW*DW-1:0]  wdata;
  logic [NR*AW-1:0]  raddr;
  logic [NR*DW-1:0]  rdata;
  logic [NR-1:0]     rbusy;
  logic              rsv_en;
  logic [AW-1:0]     rsv_addr;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [DW-1:0] m_rf [DEPTH];
  bit            m_busy [DEPTH];
  bit            m_ready;
  int            m_cnt;

  regfile_mp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NREAD(NR), .NWRITE(NW), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .ready(ready), .wen(wen), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata), .rbusy(rbusy), .rsv_en(rsv_en), .rsv_addr(rsv_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    wen = '0; waddr = '0; wdata = '0; rsv_en = 1'b0; rsv_addr = '0;
  endtask

  task automatic set_write(input int k, input int a, input logic [DW-1:0] d);
    wen[k] = 1'b1;
    waddr[k*AW +: AW] = AW'(a);
    wdata[k*DW +: DW] = d;
  endtask

  task automatic set_read(input int i, input int a);
    raddr[i*AW +: AW] = AW'(a);
  endtask

  // Compute what read port i should show right now.
  task automatic expect_read(input int i, output logic [DW-1:0] ed, output logic eb);
    int a;
    a = int'(raddr[i*AW +: AW]);
    ed = '0; eb = 1'b0;
    if (m_ready && a != 0) begin
      ed = m_rf[a];
      eb = m_busy[a];
`ifdef REGFILE_BYPASS_EN
      for (int k = 0; k < NW; k++) begin
        if (wen[k] && int'(waddr[k*AW +: AW]) == a) begin
          ed = wdata[k*DW +: DW];
          eb = rsv_en && (int'(rsv_addr) == a);
        end
      end
`endif
    end
  endtask

  task automatic check_outputs();
    logic [DW-1:0] ed;
    logic eb;
    chk("ready", {31'd0, ready}, {31'd0, m_ready});
    for (int i = 0; i < NR; i++) begin
      expect_read(i, ed, eb);
      chk($sformatf("rdata%0d@r%0d", i, raddr[i*AW +: AW]), rdata[i*DW +: DW], ed);
      chk($sformatf("rbusy%0d@r%0d", i, raddr[i*AW +: AW]), {31'd0, rbusy[i]}, {31'd0, eb});
    end
  endtask

  // Apply one clock edge to the model using the current inputs.
  task automatic model_edge();
    int a;
    if (rst) begin
      m_ready = 1'b0;
      m_cnt = 0;
      foreach (m_busy[e]) m_busy[e] = 1'b0;
    end else if (!m_ready) begin
      m_cnt++;
      if (m_cnt == DEPTH) begin
        foreach (m_rf[e]) m_rf[e] = '0;
        m_ready = 1'b1;
      end
    end else begin
      for (int k = 0; k < NW; k++) begin
        a = int'(waddr[k*AW +: AW]);
        if (wen[k] && a != 0) begin
          m_rf[a] = wdata[k*DW +: DW];
          m_busy[a] = 1'b0;
        end
      end
      if (rsv_en && rsv_addr != '0) m_busy[rsv_addr] = 1'b1;
    end
  endtask

  // Check the current outputs, then advance one clock edge and update the model.
  task automatic cycle();
    #1;
    check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  int ready_edges;

  initial begin
    rst = 1'b1; idle_inputs(); raddr = '0;
    foreach (m_rf[e]) m_rf[e] = '0;
    @(posedge clk); model_edge(); @(negedge clk);
    rst = 1'b0;

    // 1: clear sequence lasts DEPTH edges, and writes during it are ignored
    chk("ready_after_reset", {31'd0, ready}, 32'd0);
    ready_edges = 0;
    set_read(0, 3); set_read(1, 31);
    while (ready !== 1'b1 && ready_edges < 40) begin
      idle_inputs(); set_write(0, 3, 32'hDEAD); rsv_en = 1'b1; rsv_addr = 5'd3;
      cycle();
      ready_edges++;
    end
    chk("clear_edges", 32'(ready_edges), 32'd32);
    idle_inputs();
    cycle();
    chk("r3_after_clear", rdata[DW-1:0], 32'h0);
    chk("r3_busy_after_clear", {31'd0, rbusy[0]}, 32'd0);

    // 2: both ports write the same address and the higher port wins
    idle_inputs(); set_write(0, 5, 32'h1234); set_write(1, 5, 32'hABCD); cycle();
    idle_inputs(); set_read(0, 5); cycle();
    chk("r5_port1_wins", rdata[DW-1:0], 32'hABCD);

    // 3: entry 0 stays zero and never becomes busy
    idle_inputs(); set_write(0, 0, 32'hFFFF_FFFF); rsv_en = 1'b1; rsv_addr = 5'd0; cycle();
    idle_inputs(); set_read(0, 0); set_read(1, 0); cycle();
    chk("r0_data", rdata[DW +: DW], 32'h0);
    chk("r0_busy", {31'd0, rbusy[1]}, 32'd0);

    // 4: reservation and write interplay on r7
    idle_inputs(); rsv_en = 1'b1; rsv_addr = 5'd7; cycle();
    idle_inputs(); set_read(0, 7); cycle();
    chk("r7_busy_after_rsv", {31'd0, rbusy[0]}, 32'd1);
    set_write(1, 7, 32'h55); cycle();
    idle_inputs(); cycle();
    chk("r7_busy_after_write", {31'd0, rbusy[0]}, 32'd0);
    set_write(0, 7, 32'h66); rsv_en = 1'b1; rsv_addr = 5'd7; cycle();
    idle_inputs(); cycle();
    chk("r7_busy_rsv_and_write", {31'd0, rbusy[0]}, 32'd1);
    chk("r7_data_rsv_and_write", rdata[DW-1:0], 32'h66);

    // 5: same-cycle read of a register that is being written
    idle_inputs(); set_read(1, 9); set_write(0, 9, 32'h77); #1;
`ifdef REGFILE_BYPASS_EN
    chk("r9_bypass_same_cycle", rdata[DW +: DW], 32'h77);
`else
    chk("r9_no_bypass_same_cycle", rdata[DW +: DW], 32'h0);
`endif
    cycle();
    idle_inputs(); cycle();
    chk("r9_next_cycle", rdata[DW +: DW], 32'h77);

    // 6: a reset during RUN clears the busy bits and restarts the clear sequence
    idle_inputs(); rsv_en = 1'b1; rsv_addr = 5'd12; cycle();
    idle_inputs(); do_reset();
    chk("ready_low_after_rerst", {31'd0, ready}, 32'd0);
    ready_edges = 0;
    while (ready !== 1'b1 && ready_edges < 40) begin
      cycle();
      ready_edges++;
    end
    chk("clear_edges_rerun", 32'(ready_edges), 32'd32);
    set_read(0, 12); set_read(1, 9); cycle();
    chk("r12_busy_cleared", {31'd0, rbusy[0]}, 32'd0);
    chk("r9_zeroed", rdata[DW +: DW], 32'h0);

    // Random traffic against the model, including occasional resets
    for (int n = 0; n < 600; n++) begin
      idle_inputs();
      rst = ($urandom_range(0, 199) == 0);
      for (int k = 0; k < NW; k++) begin
        if ($urandom_range(0, 1) == 1) set_write(k, $urandom_range(0, 7), $urandom);
      end
      rsv_en = ($urandom_range(0, 2) == 0);
      rsv_addr = AW'($urandom_range(0, 7));
      for (int i = 0; i < NR; i++) set_read(i, $urandom_range(0, 9));
      cycle();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Hard bound so the run always terminates
  initial begin
    #2000000;
    $display("FAIL timeout reached observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
